uart_autobaud_rx: RTL and testbench
===================================

UART_AUTOBAUD_RX -- requirements
Module: uart_autobaud_rx

Interface
REQ-001 Parameter: DIV_W, default 16, width of the bit-period counter and the measured divisor.
REQ-002 Parameter: MIN_DIV, default 16, smallest accepted bit period in clk cycles.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 rx  input  1  asynchronous serial line, idle high, 8N1, LSB first.
REQ-006 relock  input  1  single-cycle pulse; discards the current lock and restarts the baud hunt.
REQ-007 rx_data  output  8  last received byte; holds until the next rx_valid.
REQ-008 rx_valid  output  1  one-cycle pulse; rx_data is new.
REQ-009 frame_err  output  1  one-cycle pulse; stop bit sampled low.
REQ-010 locked  output  1  high while a baud divisor is established.
REQ-011 baud_div  output  DIV_W  measured bit period in clk cycles; valid while locked.

Function
REQ-012 rx SHALL pass through a 2-flop synchronizer (reset value 1); all edge detection and sampling SHALL use the synchronized signal.
REQ-013 States: HUNT, MEASURE, VERIFY, IDLE, START, DATA, STOP; reset state HUNT.
REQ-014 HUNT: on a synced falling edge -> MEASURE, counter = 1.
REQ-015 MEASURE: counter increments each cycle while synced rx is low; on the rising edge, the counter value becomes the candidate divisor.
REQ-016 MEASURE abort: counter reaches 2^DIV_W-1 -> HUNT; candidate < MIN_DIV on the rising edge -> HUNT; locked stays 0 in both cases.
REQ-017 VERIFY: receives the rest of the sync frame using the candidate divisor. First sample at div>>1 cycles after the rising edge, then every div cycles: 8 data bits, then stop.
REQ-018 VERIFY passes when the byte equals SYNC_CHAR (0x55) and the stop bit is high: baud_div <= candidate, locked <= 1, -> IDLE. No rx_valid is raised for the sync byte.
REQ-019 VERIFY fails on any other byte or a low stop bit -> HUNT, locked stays 0, no frame_err.
REQ-020 IDLE (locked): synced falling edge -> START, bit counter cleared.
REQ-021 START: sample at div>>1 cycles. Low -> DATA. High (false start) -> IDLE with no output pulse.
REQ-022 DATA: sample every div cycles, shifting LSB first; after the 8th sample -> STOP.
REQ-023 STOP: sample div cycles after the last data sample. High -> rx_data updated and rx_valid pulsed in the next cycle. Low -> frame_err pulsed in the next cycle and rx_data unchanged. Both cases -> IDLE.
REQ-024 Two consecutive frame errors SHALL clear locked and go to HUNT. A good frame clears the error count.
REQ-025 relock SHALL take priority over all states: locked <= 0, error count cleared, -> HUNT next cycle, no output pulses. Any frame in progress is dropped.
REQ-026 rx_valid and frame_err SHALL never be asserted in the same cycle, nor while locked=0.
REQ-027 Timer arithmetic SHALL be DIV_W bits unsigned; the half-period is div>>1 (truncating).

Reset
REQ-028 On rst: state HUNT, rx_data=0, rx_valid=0, frame_err=0, locked=0, baud_div=0, synchronizer=1, all counters 0.
REQ-029 rst asserted mid-frame SHALL abandon the frame with no pulses; after release, the block SHALL ignore the line until the next falling edge.

Structure
REQ-030 Shared package uart_pkg SHALL hold the state enum, DATA_BITS=8 and SYNC_CHAR=8'h55.
REQ-031 One sub-module, uart_bit_timer: loads div or div>>1, counts down, and emits a one-cycle sample strobe.
REQ-032 Target size: 150-300 lines of RTL.

Verification
REQ-033 rst, then 0x55 at 104 clk/bit -> locked=1, baud_div=104, no rx_valid; then 0xA3 -> rx_valid once, rx_data=0xA3.
REQ-034 Unlocked, 0x54 sent at 104 clk/bit -> locked stays 0 and the state returns to HUNT; then 0x55 -> locks.
REQ-035 Unlocked, a 5-cycle low glitch -> locked stays 0, no pulses; a following 0x55 at 32 clk/bit -> baud_div=32.
REQ-036 Locked at 104, two frames with stop bit=0 -> two frame_err pulses, then locked=0; a 3-cycle low glitch while locked -> no pulses.
REQ-037 Locked, relock pulse mid-byte -> locked=0 next cycle, no rx_valid; rst mid-byte -> all outputs 0.
REQ-038 Locked at 104, back-to-back bytes 0x00, 0xFF at ±2% bit-rate skew -> both received correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and constants for the auto-baud UART receiver.
// Holds the receiver state encoding and the sync-frame definition.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        MEASURE,
        VERIFY,
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
    localparam logic [7:0] SYNC_CHAR = 8'h55;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer for the UART receiver.
// A load sets the delay; a strobe fires once when the count expires.
module uart_bit_timer #(
    parameter int DIV_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [DIV_W-1:0] load_val,
    output logic             strobe
);

    logic [DIV_W-1:0] cnt;

    // Count down to zero; loading zero parks the timer.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - DIV_W'(1);
        end
    end

    assign strobe = (cnt == DIV_W'(1));

endmodule

// File: rtl/uart_autobaud_rx.sv
// 8N1 UART receiver that measures its bit period from a 0x55 sync byte.
// Loses lock after two consecutive framing errors or on relock.
module uart_autobaud_rx
    import uart_pkg::*;
#(
    parameter int DIV_W   = 16,
    parameter int MIN_DIV = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx,
    input  logic             relock,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             frame_err,
    output logic             locked,
    output logic [DIV_W-1:0] baud_div
);

    state_t           state, state_n;
    logic             rx_s1, rx_s2, rx_d;
    logic             fall, rise;
    logic [DIV_W-1:0] meas_cnt;
    logic [DIV_W-1:0] cand;
    logic [3:0]       bit_cnt;
    logic [7:0]       shift;
    logic             err_cnt;
    logic             tmr_load;
    logic [DIV_W-1:0] tmr_val;
    logic             strobe;
    logic             meas_start, meas_inc, cand_take;
    logic             bit_clr, do_shift;
    logic             lock_set, byte_ok, byte_err;

    assign fall = rx_d & ~rx_s2;
    assign rise = ~rx_d & rx_s2;

    uart_bit_timer #(.DIV_W(DIV_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .strobe   (strobe)
    );

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= HUNT;
        else     state <= state_n;
    end

    // Next-state logic, timer control and datapath enables.
    always_comb begin
        state_n    = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        meas_start = 1'b0;
        meas_inc   = 1'b0;
        cand_take  = 1'b0;
        bit_clr    = 1'b0;
        do_shift   = 1'b0;
        lock_set   = 1'b0;
        byte_ok    = 1'b0;
        byte_err   = 1'b0;
        unique case (state)
            HUNT: begin
                if (fall) begin
                    state_n    = MEASURE;
                    meas_start = 1'b1;
                end
            end
            MEASURE: begin
                if (rise) begin
                    if (meas_cnt < DIV_W'(MIN_DIV)) begin
                        state_n = HUNT;
                    end else begin
                        state_n   = VERIFY;
                        cand_take = 1'b1;
                        bit_clr   = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = meas_cnt >> 1;
                    end
                end else if (meas_cnt == '1) begin
                    state_n = HUNT;
                end else begin
                    meas_inc = 1'b1;
                end
            end
            VERIFY: begin
                if (strobe) begin
                    tmr_load = 1'b1;
                    if (int'(bit_cnt) < DATA_BITS) begin
                        do_shift = 1'b1;
                        tmr_val  = cand;
                    end else if (rx_s2 && shift == SYNC_CHAR) begin
                        lock_set = 1'b1;
                        state_n  = IDLE;
                    end else begin
                        state_n = HUNT;
                    end
                end
            end
            IDLE: begin
                if (fall) begin
                    state_n  = START;
                    bit_clr  = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = baud_div >> 1;
                end
            end
            START: begin
                if (strobe) begin
                    tmr_load = 1'b1;
                    if (!rx_s2) begin
                        state_n = DATA;
                        tmr_val = baud_div;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            DATA: begin
                if (strobe) begin
                    do_shift = 1'b1;
                    tmr_load = 1'b1;
                    tmr_val  = baud_div;
                    if (bit_cnt == 4'(DATA_BITS - 1)) state_n = STOP;
                end
            end
            STOP: begin
                if (strobe) begin
                    tmr_load = 1'b1;
                    if (rx_s2) begin
                        byte_ok = 1'b1;
                        state_n = IDLE;
                    end else begin
                        byte_err = 1'b1;
                        state_n  = err_cnt ? HUNT : IDLE;
                    end
                end
            end
            default: state_n = HUNT;
        endcase
        if (relock) begin
            state_n  = HUNT;
            tmr_load = 1'b1;
            tmr_val  = '0;
            lock_set = 1'b0;
            byte_ok  = 1'b0;
            byte_err = 1'b0;
            do_shift = 1'b0;
        end
    end

    // Measurement, shift register, lock and output pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            meas_cnt  <= '0;
            cand      <= '0;
            bit_cnt   <= '0;
            shift     <= '0;
            err_cnt   <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            locked    <= 1'b0;
            baud_div  <= '0;
        end else begin
            rx_valid  <= byte_ok;
            frame_err <= byte_err;
            if (meas_start)    meas_cnt <= DIV_W'(1);
            else if (meas_inc) meas_cnt <= meas_cnt + DIV_W'(1);
            if (cand_take) cand <= meas_cnt;
            if (bit_clr) begin
                bit_cnt <= '0;
            end else if (do_shift) begin
                shift   <= {rx_s2, shift[7:1]};
                bit_cnt <= bit_cnt + 4'd1;
            end
            if (byte_ok) rx_data <= shift;
            if (relock || byte_ok || lock_set) err_cnt <= 1'b0;
            else if (byte_err)                 err_cnt <= ~err_cnt;
            if (relock || state == HUNT) locked <= 1'b0;
            else if (lock_set)           locked <= 1'b1;
            if (lock_set) baud_div <= cand;
        end
    end

endmodule

// File: tb/tb_uart_autobaud_rx.sv
// Randomized bench for the auto-baud UART receiver.
// A line-level model predicts pulses, lock state and divisor.
module tb_uart_autobaud_rx;

    localparam int DIV_W   = 16;
    localparam int MIN_DIV = 16;

    logic             clk = 1'b0;
    logic             rst;
    logic             rx;
    logic             relock;
    logic [7:0]       rx_data;
    logic             rx_valid;
    logic             frame_err;
    logic             locked;
    logic [DIV_W-1:0] baud_div;

    always #5 clk = ~clk;

    uart_autobaud_rx #(.DIV_W(DIV_W), .MIN_DIV(MIN_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .relock    (relock),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .frame_err (frame_err),
        .locked    (locked),
        .baud_div  (baud_div)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse monitor: counts pulses and illegal pulse combinations.
    int n_valid = 0;
    int n_ferr  = 0;
    int n_bad   = 0;
    always @(negedge clk) begin
        if (rx_valid) n_valid++;
        if (frame_err) n_ferr++;
        if ((rx_valid && frame_err) ||
            ((rx_valid || frame_err) && !locked)) n_bad++;
    end

    // Line waveform, one entry per clock cycle.
    logic wave[$];

    bit         m_locked = 1'b0;
    int         m_div = 0;
    int         m_err = 0;
    int         e_valid, e_ferr;
    bit         e_has;
    logic [7:0] e_data;

    function automatic logic lvl(int t);
        if (t < 0 || t >= wave.size()) return 1'b1;
        return wave[t];
    endfunction

    function automatic void add_level(logic v, int n);
        for (int k = 0; k < n; k++) wave.push_back(v);
    endfunction

    function automatic void add_frame(logic [7:0] d, logic stop, int bp);
        add_level(1'b0, bp);
        for (int i = 0; i < 8; i++) add_level(d[i], bp);
        add_level(stop, bp);
    endfunction

    // Walk the waveform the way the receiver should interpret it.
    function automatic void predict();
        int         p, f, run, s;
        logic [7:0] dv;
        logic       stop;
        p = 0;
        e_valid = 0;
        e_ferr = 0;
        e_has = 1'b0;
        while (p < wave.size()) begin
            f = -1;
            for (int i = p; i < wave.size(); i++) begin
                if (lvl(i - 1) && !lvl(i)) begin
                    f = i;
                    break;
                end
            end
            if (f < 0) break;
            if (!m_locked) begin
                run = 0;
                while (!lvl(f + run) && run < 65535) run++;
                if (run < MIN_DIV || run >= 65535) begin
                    p = f + run;
                    continue;
                end
                s = f + run + run / 2;
                for (int k = 0; k < 8; k++) dv[k] = lvl(s + k * run);
                stop = lvl(s + 8 * run);
                if (dv == 8'h55 && stop) begin
                    m_locked = 1'b1;
                    m_div = run;
                    m_err = 0;
                end
                p = s + 8 * run + 1;
            end else begin
                s = f + m_div / 2;
                if (lvl(s)) begin
                    p = s + 1;
                    continue;
                end
                for (int k = 0; k < 8; k++) dv[k] = lvl(s + (k + 1) * m_div);
                stop = lvl(s + 9 * m_div);
                if (stop) begin
                    e_valid++;
                    e_data = dv;
                    e_has = 1'b1;
                    m_err = 0;
                end else begin
                    e_ferr++;
                    m_err++;
                    if (m_err == 2) begin
                        m_locked = 1'b0;
                        m_err = 0;
                    end
                end
                p = s + 9 * m_div + 1;
            end
        end
    endfunction

    // Drive the waveform; optionally inject relock or reset mid-stream.
    task automatic run_wave(input string tag, input int rl_at, input int rs_at);
        int v0, f0, b0;
        v0 = n_valid;
        f0 = n_ferr;
        b0 = n_bad;
        if (rl_at < 0 && rs_at < 0) begin
            predict();
        end else begin
            e_valid = 0;
            e_ferr = 0;
            e_has = 1'b0;
            m_locked = 1'b0;
            m_err = 0;
        end
        for (int i = 0; i < wave.size(); i++) begin
            @(negedge clk);
            if (rl_at >= 0 && i == rl_at + 1)
                chk({tag, ".relock_locked"}, 32'(locked), 32'd0);
            if (rs_at >= 0 && i == rs_at + 2)
                chk({tag, ".rst_outputs"},
                    32'({rx_data, rx_valid, frame_err, locked, baud_div}),
                    32'd0);
            rx = wave[i];
            relock = (i == rl_at);
            rst = (rs_at >= 0 && i >= rs_at && i < rs_at + 3);
        end
        @(negedge clk);
        rx = 1'b1;
        relock = 1'b0;
        rst = 1'b0;
        repeat (4) @(negedge clk);
        chk({tag, ".valid"}, 32'(n_valid - v0), 32'(e_valid));
        chk({tag, ".ferr"}, 32'(n_ferr - f0), 32'(e_ferr));
        chk({tag, ".bad"}, 32'(n_bad - b0), 32'd0);
        chk({tag, ".locked"}, 32'(locked), 32'(m_locked));
        if (m_locked) chk({tag, ".div"}, 32'(baud_div), 32'(m_div));
        if (e_has) chk({tag, ".data"}, 32'(rx_data), 32'(e_data));
        wave.delete();
    endtask

    task automatic pulse_relock();
        @(negedge clk);
        relock = 1'b1;
        @(negedge clk);
        relock = 1'b0;
        chk("relock", 32'(locked), 32'd0);
        m_locked = 1'b0;
        m_err = 0;
    endtask

    task automatic sync(input int bp);
        add_frame(8'h55, 1'b1, bp);
        add_level(1'b1, 12 * bp);
        run_wave("sync", -1, -1);
    endtask

    initial begin
        int         bp, sk;
        logic [7:0] d;
        logic       stop;
        rst = 1'b1;
        rx = 1'b1;
        relock = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_div", 32'(baud_div), 32'd0);
        chk("rst_data", 32'(rx_data), 32'd0);
        chk("rst_pulses", 32'({rx_valid, frame_err}), 32'd0);

        sync(104);
        chk("sync104_div", 32'(baud_div), 32'd104);
        add_frame(8'hA3, 1'b1, 104);
        add_level(1'b1, 3 * 104);
        run_wave("a3", -1, -1);
        chk("a3_data", 32'(rx_data), 32'hA3);

        pulse_relock();
        add_frame(8'h54, 1'b1, 104);
        add_level(1'b1, 22 * 104);
        run_wave("bad_sync", -1, -1);
        chk("bad_sync_unlocked", 32'(locked), 32'd0);
        sync(104);

        pulse_relock();
        add_level(1'b0, 5);
        add_level(1'b1, 200);
        run_wave("glitch5", -1, -1);
        sync(32);
        chk("sync32_div", 32'(baud_div), 32'd32);

        for (int n = 0; n < 12; n++) begin
            if (!m_locked) begin
                sync($urandom_range(24, 120));
            end else begin
                sk = m_div / 50;
                bp = m_div - sk + $urandom_range(0, 2 * sk);
                d = 8'($urandom);
                stop = ($urandom_range(0, 5) != 0);
                add_frame(d, stop, bp);
                if (stop && $urandom_range(0, 1) == 1)
                    add_frame(8'($urandom), 1'($urandom_range(0, 1)), bp);
                add_level(1'b1, 3 * bp);
                run_wave("rand", -1, -1);
            end
        end

        pulse_relock();
        sync(104);
        for (int k = 0; k < 2; k++) begin
            add_frame(8'($urandom), 1'b0, 104);
            add_level(1'b1, 3 * 104);
            run_wave("stop_low", -1, -1);
        end
        chk("two_ferr_unlocked", 32'(locked), 32'd0);
        sync(104);
        add_level(1'b0, 3);
        add_level(1'b1, 300);
        run_wave("glitch3", -1, -1);

        add_frame(8'h00, 1'b1, 102);
        add_frame(8'hFF, 1'b1, 102);
        add_level(1'b1, 300);
        run_wave("skew_fast", -1, -1);
        add_frame(8'h00, 1'b1, 106);
        add_frame(8'hFF, 1'b1, 106);
        add_level(1'b1, 300);
        run_wave("skew_slow", -1, -1);

        add_frame(8'hFF, 1'b1, 104);
        add_level(1'b1, 300);
        run_wave("relock_mid", 400, -1);
        sync(104);

        add_frame(8'hF0, 1'b1, 104);
        add_level(1'b1, 300);
        run_wave("rst_mid", -1, 560);
        sync(104);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
